// File: rtl/divider_32b_seq_if.sv
// Handshake and data bundle for the sequential restoring divider.
// The master drives the requests and operands. The slave returns the results and status.
interface divider_32b_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 iEn;
   logic                 iClr;
   logic                 iStart;
   logic [2*WIDTH-1:0]   iData0;
   logic [WIDTH-1:0]     iData1;
   logic [WIDTH-1:0]     oQuot;
   logic [WIDTH-1:0]     oRem;
   logic                 oBusy;
   logic                 oDone;
   logic                 oErr;

   modport master (
      output iEn, iClr, iStart, iData0, iData1,
      input  oQuot, oRem, oBusy, oDone, oErr
   );

   modport slave (
      input  iEn, iClr, iStart, iData0, iData1,
      output oQuot, oRem, oBusy, oDone, oErr
   );
endinterface

// File: rtl/divider_32b_seq.sv
// Sequential unsigned divider that divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor.
// It uses restoring division and produces one quotient bit per enabled clock.
module divider_32b_seq #(
   parameter int unsigned WIDTH = 32
) (
   input logic               iClk,
   input logic               iRstN,
   divider_32b_seq_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [WIDTH-1:0]   dvd, dvd_nx;      // low dividend half, refilled with quotient bits
   logic [WIDTH-1:0]   dvs, dvs_nx;
   logic [WIDTH:0]     prem, prem_nx;    // partial remainder, one guard bit
   logic [WIDTH-1:0]   quot, quot_nx;
   logic [WIDTH-1:0]   rem, rem_nx;
   logic               err, err_nx;

   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic               ge;
   logic               accept;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      dvd_nx   = dvd;
      dvs_nx   = dvs;
      prem_nx  = prem;
      quot_nx  = quot;
      rem_nx   = rem;
      err_nx   = err;

      shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      ge       = (shifted >= {1'b0, dvs});
      accept   = bus.iEn && bus.iStart && (state == IDLE || state == DONE);

      if (bus.iClr) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         dvd_nx   = '0;
         dvs_nx   = '0;
         prem_nx  = '0;
         quot_nx  = '0;
         rem_nx   = '0;
         err_nx   = '0;
      end else if (bus.iEn) begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  dvd_nx  = bus.iData0[WIDTH-1:0];
                  dvs_nx  = bus.iData1;
                  prem_nx = {1'b0, bus.iData0[2*WIDTH-1:WIDTH]};
                  cnt_nx  = '0;
                  if (bus.iData1 == '0) begin
                     state_nx = DONE;
                     quot_nx  = '1;
                     rem_nx   = bus.iData0[WIDTH-1:0];
                     err_nx   = 1'b1;
                  end else if (bus.iData0[2*WIDTH-1:WIDTH] >= bus.iData1) begin
                     // A high half at or above the divisor cannot give a quotient that fits in WIDTH bits.
                     state_nx = DONE;
                     quot_nx  = '1;
                     rem_nx   = '0;
                     err_nx   = 1'b1;
                  end else begin
                     state_nx = CALC;
                     err_nx   = 1'b0;
                  end
               end else if (state == DONE) begin
                  state_nx = IDLE;
               end
            end
            CALC: begin
               prem_nx = ge ? diff : shifted;
               dvd_nx  = {dvd[WIDTH-2:0], ge};
               if (cnt == CW'(WIDTH-1)) begin
                  state_nx = DONE;
                  cnt_nx   = '0;
                  quot_nx  = {dvd[WIDTH-2:0], ge};
                  rem_nx   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
               end else begin
                  cnt_nx   = cnt + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state <= IDLE;
         cnt   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         prem  <= '0;
         quot  <= '0;
         rem   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         dvd   <= dvd_nx;
         dvs   <= dvs_nx;
         prem  <= prem_nx;
         quot  <= quot_nx;
         rem   <= rem_nx;
         err   <= err_nx;
      end
   end

   assign bus.oQuot = quot;
   assign bus.oRem  = rem;
   assign bus.oErr  = err;
   assign bus.oBusy = (state == CALC);
   assign bus.oDone = (state == DONE);
endmodule

// File: tb/tb_divider_32b_seq.sv
// Self-checking bench for divider_32b_seq. It checks directed cases and random cases.
// The expected results come from plain 64-bit division.
module tb_divider_32b_seq;
   localparam int unsigned W = 32;

   logic iClk;
   logic iRstN;
   int unsigned n_chk;
   int unsigned n_pass;

   divider_32b_seq_if #(.WIDTH(W)) bus ();

   divider_32b_seq #(.WIDTH(W)) dut (
      .iClk  (iClk),
      .iRstN (iRstN),
      .bus   (bus)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge iClk);
      #1;
   endtask

   task automatic ref_div(input logic [63:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic e);
      logic [63:0] full_q;
      if (b == 32'd0) begin
         q = '1; r = a[31:0]; e = 1'b1;
      end else begin
         full_q = a / {32'd0, b};
         if (full_q > 64'hFFFF_FFFF) begin
            q = '1; r = '0; e = 1'b1;
         end else begin
            q = full_q[31:0];
            r = 32'(a % {32'd0, b});
            e = 1'b0;
         end
      end
   endtask

   task automatic run_div(input string tag, input logic [63:0] a, input logic [31:0] b,
                          input int unsigned stall_at, input int unsigned stall_n);
      logic [31:0] eq, er, pq, pr;
      logic        ee;
      int unsigned n, busy_cnt;
      ref_div(a, b, eq, er, ee);
      pq = bus.oQuot;
      pr = bus.oRem;
      bus.iData0  = a;
      bus.iData1  = b;
      bus.iEn     = 1'b1;
      bus.iStart  = 1'b1;
      tick;
      bus.iStart  = 1'b0;
      if (ee) begin
         check({tag, "_done"}, 64'(bus.oDone), 64'd1);
         check({tag, "_busy"}, 64'(bus.oBusy), 64'd0);
      end else begin
         n = 0;
         busy_cnt = 0;
         while (!bus.oDone && n < 200) begin
            if (bus.oBusy) busy_cnt++;
            if (n == 3) begin
               check({tag, "_hold_q"}, 64'(bus.oQuot), 64'(pq));
               check({tag, "_hold_r"}, 64'(bus.oRem), 64'(pr));
               check({tag, "_calc_err"}, 64'(bus.oErr), 64'd0);
            end
            bus.iStart = (n == 5);
            bus.iEn    = !(stall_n != 0 && n >= stall_at && n < stall_at + stall_n);
            tick;
            n++;
         end
         bus.iStart = 1'b0;
         bus.iEn    = 1'b1;
         check({tag, "_latency"}, 64'(n), 64'(W + stall_n));
         check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + stall_n));
      end
      check({tag, "_quot"}, 64'(bus.oQuot), 64'(eq));
      check({tag, "_rem"},  64'(bus.oRem),  64'(er));
      check({tag, "_err"},  64'(bus.oErr),  64'(ee));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_quot"}, 64'(bus.oQuot), 64'd0);
      check({tag, "_rem"},  64'(bus.oRem),  64'd0);
      check({tag, "_busy"}, 64'(bus.oBusy), 64'd0);
      check({tag, "_done"}, 64'(bus.oDone), 64'd0);
      check({tag, "_err"},  64'(bus.oErr),  64'd0);
   endtask

   initial begin
      logic [31:0] b, hi;
      logic [63:0] a;
      n_chk  = 0;
      n_pass = 0;
      bus.iEn    = 1'b1;
      bus.iClr   = 1'b0;
      bus.iStart = 1'b0;
      bus.iData0 = '0;
      bus.iData1 = '0;
      iRstN = 1'b0;
      repeat (3) tick;
      check_zero("reset");
      iRstN = 1'b1;
      tick;

      run_div("d100_7", 64'd100, 32'd7, 0, 0);
      tick;
      check("done_pulse", 64'(bus.oDone), 64'd0);
      check("idle_hold_q", 64'(bus.oQuot), 64'd14);

      run_div("stall", 64'd100, 32'd7, 10, 5);
      tick;

      run_div("b2b_a", 64'h0000_0001_0000_0000, 32'd2, 0, 0);
      run_div("b2b_b", 64'h0000_0000_FFFF_FFFF, 32'h10, 0, 0);

      run_div("div0", 64'd5, 32'd0, 0, 0);
      tick;
      run_div("ovf", 64'h0000_0005_0000_0000, 32'd5, 0, 0);
      tick;
      run_div("max", 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 0, 0);

      // A clear at step 10 wipes the held results of the previous operation.
      bus.iData0 = 64'd100;
      bus.iData1 = 32'd7;
      bus.iStart = 1'b1;
      tick;
      bus.iStart = 1'b0;
      repeat (10) tick;
      bus.iClr = 1'b1;
      bus.iEn  = 1'b0;
      tick;
      bus.iClr = 1'b0;
      bus.iEn  = 1'b1;
      check_zero("clr");

      run_div("pre_rst", 64'd1000, 32'd3, 0, 0);
      bus.iData0 = 64'd100;
      bus.iData1 = 32'd7;
      bus.iStart = 1'b1;
      tick;
      bus.iStart = 1'b0;
      repeat (4) tick;
      iRstN = 1'b0;
      #2;
      check_zero("async_rst");
      #2;
      iRstN = 1'b1;
      run_div("d9_3", 64'd9, 32'd3, 0, 0);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         hi = $urandom;
         if (b != 0 && $urandom_range(0, 3) != 0) hi = hi % b;
         a = {hi, 32'($urandom)};
         run_div($sformatf("rnd%0d", i), a, b, $urandom_range(1, 20), $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) tick;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
